cpu_trace_uart_tx: RTL
======================

# cpu_trace_uart_tx

Board-side trace transmitter for the 32-bit CPU. It samples the core's observation bus (pc, inst, aluc, data) on a per-instruction strobe and buffers records in a small FIFO. Each record is serialised as a framed 8N1 UART byte stream so a host can log execution on the board in the same way the simulation bench does. It sits beside cpu_mem_final at the board top level, driving the board's UART TX pin.

## Interface

Parameters:
- CLKS_PER_BIT, default 434: clock cycles per UART bit (434 = 50 MHz / 115200); must be >= 2.
- FIFO_DEPTH, default 4: trace records buffered; power of two, >= 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- trace_valid  input  1  capture strobe; when 1 at a rising edge, the current pc/inst/aluc/data form one record.
- pc  input  32  CPU program counter.
- inst  input  32  CPU instruction word.
- aluc  input  32  CPU ALU result.
- data  input  32  CPU memory data.
- ovf_clr  input  1  synchronous clear of ovf and drop_cnt.
- txd  output  1  UART serial out, idle high.
- busy  output  1  1 while FIFO non-empty or a frame is in progress.
- ovf  output  1  sticky: at least one record dropped.
- drop_cnt  output  8  dropped-record count, saturating at 255.

## Operation

- Reset values: txd=1, busy=0, ovf=0, drop_cnt=0, FIFO empty, FSM in IDLE, all counters 0.
- Capture: on trace_valid=1, the record {pc, inst, aluc, data} is pushed if FIFO not full. If the FIFO is full, the record is dropped, ovf is set to 1 and drop_cnt increments (held at 255).
- Push while full in the same cycle as the pop at frame end: the push is accepted and the count is unchanged.
- ovf_clr=1 clears ovf and drop_cnt. If a drop occurs in the same cycle, the drop wins: ovf=1, drop_cnt=1.
- Frame format, 17 bytes:
  - byte 0: sync 0xA5;
  - bytes 1-4: pc;
  - bytes 5-8: inst;
  - bytes 9-12: aluc;
  - bytes 13-16: data.
  - Each 32-bit word is sent MSB byte first.
- Byte format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit CLKS_PER_BIT cycles.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE -> START when the FIFO is non-empty; the frame reads the FIFO head.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START (next byte) if byte index < 16.
  - At the end of the stop bit of byte 16: pop the head. Go to START of the next frame's byte 0 if the FIFO is still non-empty, else go to IDLE.
- The head record stays in the FIFO for its whole frame, so it counts toward the full condition.
- The bit counter, baud counter (log2 CLKS_PER_BIT bits) and byte index (0..16) wrap to 0 on each transition.
- busy = (state != IDLE) | FIFO non-empty.
- Reset mid-frame: txd goes high immediately (asynchronously) and the in-flight frame and all buffered records are discarded. After release, the block behaves as from power-up.

## Timing

- Capture at rising edge k with FIFO empty and FSM IDLE: busy=1 after edge k, and txd falls after edge k+1, starting the start bit of byte 0.
- A frame is 170*CLKS_PER_BIT cycles, and consecutive frames have no idle gap.
- The pop occurs on the edge that ends the stop bit of byte 16. busy falls on that same edge if the FIFO becomes empty.
- Every bit is exactly CLKS_PER_BIT cycles with no jitter. txd is registered (glitch-free).
- trace_valid may be asserted every cycle; only the FIFO-full rule limits acceptance.

## Test plan

All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.

- Reset: hold rst=0 with random inputs -> txd=1, busy=0, ovf=0, drop_cnt=0 throughout.
- Single record: pc=0x00000004, inst=0x20010005, aluc=0x00000005, data=0x0000000A, with trace_valid=1 for one cycle at edge k.
  - txd falls after edge k+1.
  - Decoded bytes: A5 00 00 00 04 20 01 00 05 00 00 00 05 00 00 00 0A.
  - busy returns to 0 exactly 680 cycles after txd first falls.
- Back-to-back: 3 records pushed on consecutive cycles -> 3 contiguous frames (2040 cycles) with no idle high gap beyond stop bits, in push order.
- Overflow: trace_valid=1 for 6 consecutive cycles while idle -> 4 records accepted, 2 dropped, ovf=1, drop_cnt=2, and exactly 4 frames transmitted.
  - Then ovf_clr=1 for one cycle -> ovf=0, drop_cnt=0.
- Reset mid-frame: assert rst=0 during data bit 3 of byte 5 -> txd=1 with no clock edge needed.
  - After release: busy=0, no residual bytes.
  - A new record then transmits starting at byte 0 (0xA5).
- Saturation and priority: 300 drops -> drop_cnt=255. ovf_clr coinciding with a drop -> ovf=1, drop_cnt=1.

Source files
------------

// File: rtl/cpu_trace_uart_tx.sv
// CPU trace transmitter: captures {pc, inst, aluc, data} records into a small FIFO
// and serialises each one as a 17-byte 8N1 UART frame led by a 0xA5 sync byte.
module cpu_trace_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trace_valid,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic [31:0] aluc,
    input  logic [31:0] data,
    input  logic        ovf_clr,
    output logic        txd,
    output logic        busy,
    output logic        ovf,
    output logic [7:0]  drop_cnt
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]    DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]    ONE_CNT   = (PTR_W + 1)'(1);
    localparam logic [4:0]        LAST_BYTE = 5'd16;
    localparam logic [7:0]        SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [127:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    state_t             r_state;
    logic [BAUD_W-1:0]  r_baud;
    logic [2:0]         r_bit;
    logic [4:0]         r_byte_idx;
    logic [7:0]         r_shift;
    logic               r_txd;
    logic               r_ovf;
    logic [7:0]         r_drop_cnt;

    logic               w_full;
    logic               w_empty;
    logic               w_bit_end;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_more;
    logic [135:0]       w_frame;
    logic [4:0]         w_sel;
    logic [7:0]         w_byte;

    assign w_full    = (r_count == DEPTH_CNT);
    assign w_empty   = (r_count == '0);
    assign w_bit_end = (r_state != S_IDLE) && (r_baud == BAUD_LAST);
    assign w_pop     = (r_state == S_STOP) && w_bit_end && (r_byte_idx == LAST_BYTE);

    // A pop on the same edge frees the head slot, so a push into a full FIFO is still taken.
    assign w_push = trace_valid && (!w_full || w_pop);
    assign w_drop = trace_valid && w_full && !w_pop;

    // Another frame follows if something besides the departing head remains or arrives now.
    assign w_more = (r_count != ONE_CNT) || trace_valid;

    // Frame bytes in transmit order, byte 0 in the top byte lane.
    assign w_frame = {SYNC_BYTE, r_mem[r_rd_ptr]};
    assign w_sel   = LAST_BYTE - r_byte_idx;
    assign w_byte  = w_frame[{w_sel, 3'b000} +: 8];

    // NOTE: record storage is deliberately not reset; r_count alone decides what is valid,
    // which keeps the array a plain RAM with no reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {pc, inst, aluc, data};
        end
    end

    // NOTE: every clocked block uses non-blocking assignments so all registers update
    // from the same pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_CNT;
                2'b01:   r_count <= r_count - ONE_CNT;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_bit      <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_txd      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_baud     <= '0;
                    r_bit      <= '0;
                    r_byte_idx <= '0;
                    r_txd      <= 1'b1;
                    if (!w_empty) begin
                        r_state <= S_START;
                        r_txd   <= 1'b0;
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= S_DATA;
                        r_txd   <= w_byte[0];
                        r_shift <= {1'b0, w_byte[7:1]};
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_bit   <= '0;
                            r_state <= S_STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_txd   <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end

                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_byte_idx != LAST_BYTE) begin
                            r_byte_idx <= r_byte_idx + 5'd1;
                            r_state    <= S_START;
                            r_txd      <= 1'b0;
                        end else begin
                            r_byte_idx <= '0;
                            if (w_more) begin
                                r_state <= S_START;
                                r_txd   <= 1'b0;
                            end else begin
                                r_state <= S_IDLE;
                                r_txd   <= 1'b1;
                            end
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    // A drop in the same cycle as a clear wins and restarts the count at one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (ovf_clr) begin
                r_drop_cnt <= 8'd1;
            end else if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end else if (ovf_clr) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign txd      = r_txd;
    assign busy     = (r_state != S_IDLE) || !w_empty;
    assign ovf      = r_ovf;
    assign drop_cnt = r_drop_cnt;

endmodule
